merge_rr: RTL



---
 rtl/merge_rr.sv | 135 +++++++++++++
 1 files changed

// File: rtl/merge_rr.sv
// Round-robin N:1 merge of native request/response buses; a grant is held for a whole transaction.
// Optional MERGE_RR_BACK2BACK_EN: re-arbitrate in the ready cycle so consecutive grants have no IDLE bubble.
module merge_rr #(
    parameter byte TYPE      = "D",
    parameter int  N_MASTERS = 2,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    localparam int REQ_W     = (TYPE == "I") ? (1 + ADDR_W) : (1 + ADDR_W + DATA_W + DATA_W / 8),
    localparam int RESP_W    = DATA_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [N_MASTERS-1:0]        grant,
    output logic                        busy
);
    localparam int PTR_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [N_MASTERS-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;

    logic [N_MASTERS-1:0]   m_valid;
    logic [2*N_MASTERS-1:0] valid_rot;
    logic [PTR_W-1:0]       scan_base;
    logic [PTR_W-1:0]       pick_idx;
    logic                   skip_owner;
    logic                   pick_found;
    logic                   s_ready;

    assign s_ready = s_resp[0];

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] v);
        if (int'(v) >= N_MASTERS - 1) return '0;
        return PTR_W'(int'(v) + 1);
    endfunction

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // In the back-to-back build the ready cycle scans from owner+1, and the owner
    // sits at the last rotated position, so it can be masked out by position.
    always_comb begin
        scan_base  = ptr_q;
        skip_owner = 1'b0;
`ifdef MERGE_RR_BACK2BACK_EN
        if (state_q == BUSY) begin
            scan_base  = wrap_inc(owner_q);
            skip_owner = 1'b1;
        end
`endif
    end

    always_comb begin
        valid_rot  = {m_valid, m_valid} >> scan_base;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!pick_found && valid_rot[k] && !(skip_owner && k == N_MASTERS - 1)) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'((int'(scan_base) + k) % N_MASTERS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    owner_d = pick_idx;
                    grant_d = N_MASTERS'(1) << pick_idx;
                end
            end
            BUSY: begin
                if (s_ready) begin
                    ptr_d   = wrap_inc(owner_q);
                    state_d = IDLE;
                    grant_d = '0;
`ifdef MERGE_RR_BACK2BACK_EN
                    if (pick_found) begin
                        state_d = BUSY;
                        owner_d = pick_idx;
                        grant_d = N_MASTERS'(1) << pick_idx;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    // The owner's request passes straight through, so it follows the master even if valid drops.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        if (state_q == BUSY) begin
            s_req = m_req[int'(owner_q)*REQ_W +: REQ_W];
            for (int i = 0; i < N_MASTERS; i++) begin
                if (grant_q[i]) m_resp[i*RESP_W +: RESP_W] = s_resp;
            end
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule
